// File: rtl/buzz_pkg.sv
// Shared constants for the buzzer arbiter: note half-periods, grant bit
// positions, FSM encoding and the per-source melody tables.
package buzz_pkg;

  localparam logic [16:0] NOTE_C    = 17'd95556;
  localparam logic [16:0] NOTE_D    = 17'd85131;
  localparam logic [16:0] NOTE_E    = 17'd75843;
  localparam logic [16:0] NOTE_G    = 17'd63776;
  localparam logic [16:0] NOTE_C6   = 17'd47778;
  localparam logic [16:0] NOTE_REST = 17'd0;

  localparam int G_ALARM = 2;
  localparam int G_TIMER = 1;
  localparam int G_BEEP  = 0;

  localparam logic [2:0] GR_NONE  = 3'b000;
  localparam logic [2:0] GR_BEEP  = 3'b001;
  localparam logic [2:0] GR_TIMER = 3'b010;
  localparam logic [2:0] GR_ALARM = 3'b100;

  localparam int ALARM_LEN = 8;
  localparam int TIMER_LEN = 2;
  localparam int BEEP_LEN  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  function automatic logic [2:0] melody_last(input logic [2:0] grant);
    case (grant)
      GR_ALARM: return 3'(ALARM_LEN - 1);
      GR_TIMER: return 3'(TIMER_LEN - 1);
      GR_BEEP:  return 3'(BEEP_LEN - 1);
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [16:0] melody_note(input logic [2:0] grant, input logic [2:0] idx);
    case (grant)
      GR_ALARM: begin
        case (idx)
          3'd0, 3'd4, 3'd5, 3'd6: return NOTE_E;
          3'd1, 3'd3:             return NOTE_D;
          3'd2:                   return NOTE_C;
          default:                return NOTE_REST;
        endcase
      end
      GR_TIMER: return idx[0] ? NOTE_REST : NOTE_C6;
      GR_BEEP:  return NOTE_C6;
      default:  return NOTE_REST;
    endcase
  endfunction

endpackage

// File: rtl/buzz_tone.sv
// Square-wave tone generator: counts a half-period and toggles the tone bit.
// restart zeroes the counter and forces the tone low for a new note.
module buzz_tone #(
  parameter int HALF_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic [HALF_W-1:0] half,
  output logic              tone_nxt
);

  logic [HALF_W-1:0] cnt, cnt_nxt;
  logic              tone;

  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    tone_nxt = tone;
    if (restart) begin
      cnt_nxt  = '0;
      tone_nxt = 1'b0;
    end else if (cnt >= half - 1'b1) begin
      cnt_nxt  = '0;
      tone_nxt = ~tone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tone <= tone_nxt;
    end
  end

endmodule

// File: rtl/buzz_arb.sv
// Priority arbiter and melody sequencer for the shared buzzer (alarm > timer > beep).
// Optional snooze support is compiled in with `define BUZZ_ARB_SNOOZE_EN.
module buzz_arb
  import buzz_pkg::*;
#(
  parameter int BEAT_CYC   = 25000000,
  parameter int GAP_CYC    = 2500000,
  parameter int NOTE_SHIFT = 0
`ifdef BUZZ_ARB_SNOOZE_EN
  ,
  parameter int SNOOZE_BEATS = 600
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_alarm_req,
  input  logic       i_timer_req,
  input  logic       i_beep,
  input  logic       i_mute,
`ifdef BUZZ_ARB_SNOOZE_EN
  input  logic       i_snooze,
`endif
  output logic       o_buzz,
  output logic [2:0] o_grant,
  output logic       o_busy,
  output logic [2:0] o_note_idx
);

  localparam int BW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYC - 1);
  localparam logic [BW-1:0] SOUND_END = BW'(BEAT_CYC - GAP_CYC);

  state_t        state, state_nxt;
  logic [2:0]    grant, grant_nxt;
  logic [2:0]    note, note_nxt;
  logic [2:0]    pick, pick_low;
  logic [BW-1:0] beat, beat_nxt;
  logic          beep_pend, beep_pend_nxt;
  logic          blk_alarm, blk_alarm_nxt;
  logic          blk_timer, blk_timer_nxt;
  logic          take, drop, alarm_ok, timer_ok, snoozed;
  logic          restart, tone_nxt, buzz_nxt;
  logic [16:0]   note_raw, note_shr, half;

`ifdef BUZZ_ARB_SNOOZE_EN
  localparam int SW = (SNOOZE_BEATS > 0) ? $clog2(SNOOZE_BEATS + 1) : 1;
  logic [SW-1:0] snz_left;
  logic [BW-1:0] snz_tick;
  logic          snooze_set;

  assign snoozed = (snz_left != '0);

  // The snooze cycle itself counts as the first suppressed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_left <= '0;
      snz_tick <= '0;
    end else if (i_mute) begin
      snz_left <= '0;
      snz_tick <= '0;
    end else if (snooze_set) begin
      snz_left <= SW'(SNOOZE_BEATS);
      snz_tick <= BW'(1);
    end else if (snoozed) begin
      if (snz_tick == BEAT_LAST) begin
        snz_tick <= '0;
        snz_left <= snz_left - 1'b1;
      end else begin
        snz_tick <= snz_tick + 1'b1;
      end
    end
  end
`else
  assign snoozed = 1'b0;
`endif

  assign alarm_ok = i_alarm_req & ~blk_alarm & ~snoozed;
  assign timer_ok = i_timer_req & ~blk_timer;
  assign pick_low = timer_ok ? GR_TIMER : (beep_pend ? GR_BEEP : GR_NONE);
  assign pick     = alarm_ok ? GR_ALARM : pick_low;
  assign drop     = (grant[G_ALARM] & ~i_alarm_req) | (grant[G_TIMER] & ~i_timer_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      note      <= '0;
      beat      <= '0;
      beep_pend <= 1'b0;
      blk_alarm <= 1'b0;
      blk_timer <= 1'b0;
      o_buzz    <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      note      <= note_nxt;
      beat      <= beat_nxt;
      beep_pend <= beep_pend_nxt;
      blk_alarm <= blk_alarm_nxt;
      blk_timer <= blk_timer_nxt;
      o_buzz    <= buzz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    note_nxt  = note;
    beat_nxt  = beat;
    take      = 1'b0;
`ifdef BUZZ_ARB_SNOOZE_EN
    snooze_set = 1'b0;
`endif
    if (i_mute) begin
      state_nxt = ST_IDLE;
      grant_nxt = GR_NONE;
      note_nxt  = '0;
      beat_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != GR_NONE) begin
            state_nxt = ST_PLAY;
            grant_nxt = pick;
            take      = 1'b1;
            note_nxt  = '0;
            beat_nxt  = '0;
          end
        end
        ST_PLAY: begin
          if (drop) begin
            state_nxt = ST_IDLE;
            grant_nxt = GR_NONE;
            note_nxt  = '0;
            beat_nxt  = '0;
`ifdef BUZZ_ARB_SNOOZE_EN
          end else if (grant[G_ALARM] && i_snooze) begin
            snooze_set = 1'b1;
            note_nxt   = '0;
            beat_nxt   = '0;
            grant_nxt  = pick_low;
            take       = (pick_low != GR_NONE);
            state_nxt  = (pick_low != GR_NONE) ? ST_PLAY : ST_IDLE;
`endif
          end else if (beat == BEAT_LAST) begin
            beat_nxt = '0;
            if (grant[G_BEEP]) begin
              // A beep is a single beat; hand over to whoever is waiting.
              grant_nxt = pick;
              take      = (pick != GR_NONE);
              note_nxt  = '0;
              state_nxt = (pick != GR_NONE) ? ST_PLAY : ST_IDLE;
            end else if (pick > grant) begin
              grant_nxt = pick;
              take      = 1'b1;
              note_nxt  = '0;
            end else begin
              note_nxt = (note == melody_last(grant)) ? 3'd0 : note + 3'd1;
            end
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (i_mute)
      beep_pend_nxt = 1'b0;
    else if (take && grant_nxt[G_BEEP])
      beep_pend_nxt = i_beep;
    else
      beep_pend_nxt = beep_pend | i_beep;

    blk_alarm_nxt = (i_mute & grant[G_ALARM]) | (blk_alarm & i_alarm_req);
    blk_timer_nxt = (i_mute & grant[G_TIMER]) | (blk_timer & i_timer_req);
  end

  // o_buzz is registered from next-state values so it lines up with grant/note.
  always_comb begin
    restart  = (state_nxt != ST_PLAY) || (beat_nxt == '0);
    note_raw = melody_note(grant, note);
    note_shr = note_raw >> NOTE_SHIFT;
    half     = (note_shr == '0) ? 17'd1 : note_shr;
    buzz_nxt = (state_nxt == ST_PLAY) && tone_nxt && (beat_nxt < SOUND_END) &&
               (melody_note(grant_nxt, note_nxt) != NOTE_REST);
    o_grant    = grant;
    o_busy     = |grant;
    o_note_idx = note;
  end

  buzz_tone #(.HALF_W(17)) u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .half     (half),
    .tone_nxt (tone_nxt)
  );

endmodule

// File: tb/tb_buzz_arb.sv
// Scoreboard bench for buzz_arb: a cycle-level reference model predicts the
// outputs from elapsed-time arithmetic; a negedge monitor pops and compares.
module tb_buzz_arb;

  localparam int BEAT  = 100;
  localparam int GAP   = 10;
  localparam int SHIFT = 10;
  localparam int SNZ   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       alarm_req = 1'b0;
  logic       timer_req = 1'b0;
  logic       beep = 1'b0;
  logic       mute = 1'b0;
  logic       snooze = 1'b0;
  logic       buzz, busy;
  logic [2:0] grant, note_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb[$];

  int m_cur = 0;
  int m_t   = 0;
  int m_snz = 0;
  bit m_pend = 1'b0, m_blk_a = 1'b0, m_blk_t = 1'b0;

  always #5 clk = ~clk;

  buzz_arb #(
    .BEAT_CYC   (BEAT),
    .GAP_CYC    (GAP),
    .NOTE_SHIFT (SHIFT)
`ifdef BUZZ_ARB_SNOOZE_EN
    ,
    .SNOOZE_BEATS (SNZ)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alarm_req (alarm_req),
    .i_timer_req (timer_req),
    .i_beep      (beep),
    .i_mute      (mute),
`ifdef BUZZ_ARB_SNOOZE_EN
    .i_snooze    (snooze),
`endif
    .o_buzz      (buzz),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_note_idx  (note_idx)
  );

  // Source codes equal the one-hot grant value: 4 alarm, 2 timer, 1 beep.
  function automatic int note_raw(input int src, input int n);
    case (src)
      4: case (n)
           0, 4, 5, 6: return 75843;
           1, 3:       return 85131;
           2:          return 95556;
           default:    return 0;
         endcase
      2: return (n == 0) ? 47778 : 0;
      1: return 47778;
      default: return 0;
    endcase
  endfunction

  function automatic int melody_len(input int src);
    return (src == 4) ? 8 : (src == 2) ? 2 : 1;
  endfunction

  function automatic logic [7:0] expect_of(input int src, input int t);
    int n, b, h;
    bit bz;
    if (src == 0) return 8'd0;
    n = (t / BEAT) % melody_len(src);
    b = t % BEAT;
    h = note_raw(src, n) >> SHIFT;
    if (h < 1) h = 1;
    bz = (b < BEAT - GAP) && (note_raw(src, n) != 0) && ((b / h) % 2 == 1);
    return {3'(src), 3'(n), 1'b1, bz};
  endfunction

  task automatic model_step();
    bit a_ok, t_ok, consume, nblk_a, nblk_t;
    int pk, plow, nc, nt, b;
    a_ok    = alarm_req && !m_blk_a && (m_snz == 0);
    t_ok    = timer_req && !m_blk_t;
    plow    = t_ok ? 2 : (m_pend ? 1 : 0);
    pk      = a_ok ? 4 : plow;
    b       = m_t % BEAT;
    nc      = m_cur;
    nt      = m_t + 1;
    consume = 1'b0;
    nblk_a  = m_blk_a && alarm_req;
    nblk_t  = m_blk_t && timer_req;
    if (m_snz > 0) m_snz--;
    if (mute) begin
      if (m_cur == 4) nblk_a = 1'b1;
      if (m_cur == 2) nblk_t = 1'b1;
      nc = 0; nt = 0; m_snz = 0;
    end else if (m_cur == 0) begin
      if (pk != 0) begin nc = pk; nt = 0; consume = (pk == 1); end
    end else if ((m_cur == 4 && !alarm_req) || (m_cur == 2 && !timer_req)) begin
      nc = 0; nt = 0;
    end else if (snooze && m_cur == 4) begin
      m_snz = SNZ * BEAT - 1;
      nc = plow; nt = 0; consume = (plow == 1);
    end else if (b == BEAT - 1) begin
      if (m_cur == 1) begin
        nc = pk; nt = 0; consume = (pk == 1);
      end else if (pk > m_cur) begin
        nc = pk; nt = 0;
      end
    end
    m_pend  = mute ? 1'b0 : (consume ? beep : (m_pend || beep));
    m_blk_a = nblk_a;
    m_blk_t = nblk_t;
    m_cur   = nc;
    m_t     = nt;
    sb.push_back(expect_of(nc, nt));
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cur = 0; m_t = 0; m_snz = 0;
      m_pend = 1'b0; m_blk_a = 1'b0; m_blk_t = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [7:0] got, exp;
    got = {grant, note_idx, busy, buzz};
    if (!rst_n) begin
      vectors++;
      if (got !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_outputs @%0t: got %b required 00000000", $time, got);
      end
    end else if (sb.size() > 0) begin
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL scoreboard @%0t: got grant=%b note=%0d busy=%b buzz=%b, required grant=%b note=%0d busy=%b buzz=%b",
                 $time, got[7:5], got[4:2], got[1], got[0], exp[7:5], exp[4:2], exp[1], exp[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, got, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int k;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Beep: latency, first tone edge, one-beat length.
    beep = 1'b1;
    tick(1);
    beep = 1'b0;
    check("beep_grant_before", int'(grant), 0);
    tick(1);
    check("beep_grant", int'(grant), 1);
    k = 0;
    while (buzz !== 1'b1 && k < 200) begin tick(1); k++; end
    check("beep_first_rise", k, 46);
    while (grant != 3'b000 && k < 300) begin tick(1); k++; end
    check("beep_length", k, 100);
    tick(10);

    // Alarm melody over a full wrap.
    alarm_req = 1'b1;
    tick(851);
    check("alarm_wrap_note", int'(note_idx), 0);
    check("alarm_wrap_grant", int'(grant), 4);
    tick(700);
    alarm_req = 1'b0;
    tick(3);
    check("alarm_drop", int'(grant), 0);

    // Timer preempted by alarm at the next beat boundary.
    timer_req = 1'b1;
    tick(1);
    check("timer_grant", int'(grant), 2);
    tick(30);
    alarm_req = 1'b1;
    tick(69);
    check("preempt_hold", int'(grant), 2);
    tick(1);
    check("preempt_grant", int'(grant), 4);
    check("preempt_note", int'(note_idx), 0);
    timer_req = 1'b0;
    tick(150);

    // Mute blocks the alarm until its request toggles.
    mute = 1'b1;
    tick(1);
    mute = 1'b0;
    check("mute_grant", int'(grant), 0);
    tick(250);
    check("mute_blocked", int'(grant), 0);
    alarm_req = 1'b0;
    tick(2);
    alarm_req = 1'b1;
    tick(2);
    check("mute_regrant", int'(grant), 4);

    // Asynchronous reset mid-note drops a pending beep.
    tick(20);
    beep = 1'b1;
    tick(1);
    beep = 1'b0;
    tick(5);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_async_grant", int'(grant), 0);
    check("rst_async_buzz", int'(buzz), 0);
    check("rst_async_note", int'(note_idx), 0);
    check("rst_async_busy", int'(busy), 0);
    alarm_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(150);
    check("rst_beep_lost", int'(grant), 0);

`ifdef BUZZ_ARB_SNOOZE_EN
    alarm_req = 1'b1;
    tick(150);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    check("snooze_release", int'(grant), 0);
    k = 1;
    while (grant == 3'b000 && k < 1000) begin tick(1); k++; end
    check("snooze_idle", k - 1, 300);
    check("snooze_regrant", int'(grant), 4);
    check("snooze_note", int'(note_idx), 0);
    alarm_req = 1'b0;
    tick(3);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 399) == 0) alarm_req = ~alarm_req;
      if ($urandom_range(0, 299) == 0) timer_req = ~timer_req;
      beep = ($urandom_range(0, 149) == 0);
      mute = ($urandom_range(0, 999) == 0);
`ifdef BUZZ_ARB_SNOOZE_EN
      snooze = ($urandom_range(0, 699) == 0);
`endif
      tick(1);
    end
    alarm_req = 1'b0;
    timer_req = 1'b0;
    beep      = 1'b0;
    mute      = 1'b0;
    snooze    = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
